// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline stage: registered decode bundle with valid/ready handshake, optional
// 2-entry skid buffer, flush-to-bubble and a saturating back-pressure counter.
module id_ex_pipe_stage #(
  parameter int unsigned              PAYLOAD_W   = 69,
  parameter int unsigned              SKID        = 1,
  parameter logic [PAYLOAD_W-1:0]     NOP_PAYLOAD = '0,
  parameter int unsigned              CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  input  logic                 flush,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e               state_q;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] skid_q;
  logic                 out_valid_q;
  logic                 in_ready_q;
  logic                 in_xfer;
  logic                 out_xfer;

  // Without the skid entry, acceptance depends combinationally on the consumer.
  assign in_ready  = (SKID != 0) ? in_ready_q : (~out_valid_q | out_ready);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_q      <= NOP_PAYLOAD;
      skid_q      <= NOP_PAYLOAD;
      stall_cnt   <= '0;
    end else begin
      if (out_valid_q && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end

      if (flush) begin
        // Any same-cycle input is consumed and dropped; an output transfer still completes.
        state_q     <= StEmpty;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
        main_q      <= NOP_PAYLOAD;
        skid_q      <= NOP_PAYLOAD;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (in_xfer) begin
              state_q     <= StOne;
              out_valid_q <= 1'b1;
              main_q      <= in_data;
            end
          end
          StOne: begin
            if (in_xfer && out_xfer) begin
              main_q <= in_data;
            end else if (in_xfer) begin
              // Only reachable with SKID != 0; combinational in_ready blocks it otherwise.
              state_q    <= StFull;
              skid_q     <= in_data;
              in_ready_q <= 1'b0;
            end else if (out_xfer) begin
              state_q     <= StEmpty;
              out_valid_q <= 1'b0;
            end
          end
          StFull: begin
            if (out_xfer) begin
              state_q    <= StOne;
              main_q     <= skid_q;
              in_ready_q <= 1'b1;
            end
          end
          default: begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Scoreboard bench for id_ex_pipe_stage: one SKID=1/CNT_W=16 instance and one
// SKID=0/CNT_W=4 instance, exercised one at a time with the same scenario list.
module tb_id_ex_pipe_stage;

  localparam int PW = 69;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel = 1'b1;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic          flush = 1'b0;

  logic          in_valid_s, out_ready_s, flush_s, rdy_s, ov_s;
  logic          in_valid_n, out_ready_n, flush_n, rdy_n, ov_n;
  logic [PW-1:0] od_s, od_n;
  logic [15:0]   st_s;
  logic [3:0]    st_n;

  logic          obs_in_ready, obs_out_valid;
  logic [PW-1:0] obs_out_data;
  logic [15:0]   obs_stall;

  logic [PW-1:0] q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  // The inactive instance sees an idle producer and an always-ready consumer.
  assign in_valid_s  = sel & in_valid;
  assign flush_s     = sel & flush;
  assign out_ready_s = sel ? out_ready : 1'b1;
  assign in_valid_n  = ~sel & in_valid;
  assign flush_n     = ~sel & flush;
  assign out_ready_n = sel ? 1'b1 : out_ready;

  assign obs_in_ready  = sel ? rdy_s : rdy_n;
  assign obs_out_valid = sel ? ov_s : ov_n;
  assign obs_out_data  = sel ? od_s : od_n;
  assign obs_stall     = sel ? st_s : {12'b0, st_n};

  id_ex_pipe_stage #(.PAYLOAD_W(PW), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(rdy_s), .in_data(in_data),
    .out_valid(ov_s), .out_ready(out_ready_s), .out_data(od_s), .flush(flush_s),
    .stall_cnt(st_s)
  );

  id_ex_pipe_stage #(.PAYLOAD_W(PW), .SKID(0), .CNT_W(4)) u_noskid (
    .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(rdy_n), .in_data(in_data),
    .out_valid(ov_n), .out_ready(out_ready_n), .out_data(od_n), .flush(flush_n),
    .stall_cnt(st_n)
  );

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (skid=%0d): got %0h expected %0h", tag, sel, obs, exp);
    end
  endtask

  // Scoreboard: push on accepted input, pop/compare on output transfer, clear on flush.
  always @(negedge clk) begin
    if (!rst) begin
      if (obs_out_valid && out_ready) begin
        check("sb_nonempty", PW'(q.size() != 0), PW'(1));
        if (q.size() != 0) begin
          check("sb_order", obs_out_data, q[0]);
          void'(q.pop_front());
        end
      end
      if (flush) q.delete();
      else if (in_valid && obs_in_ready) q.push_back(in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_offer(input logic [PW-1:0] d, input logic v, output logic acc);
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    acc = v && obs_in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    flush = 1'b0;
    tick();
    tick();
    q.delete();
    rst = 1'b0;
  endtask

  task automatic run_all();
    logic [PW-1:0] lst [3];
    logic          acc;
    int            idx;
    lst[0] = 69'h0A_1234_5678_9ABC_DEF0;
    lst[1] = 69'h15_0F0F_0F0F_0F0F_0F0B;
    lst[2] = 69'h03_C0DE_CAFE_F00D_000C;

    // Reset while holding data (FULL for the skid instance).
    do_reset();
    out_ready = 1'b0;
    step_offer(lst[0], 1'b1, acc);
    step_offer(lst[1], 1'b1, acc);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", PW'(obs_out_valid), '0);
    check("rst_out_data", obs_out_data, '0);
    check("rst_stall_cnt", PW'(obs_stall), '0);
    q.delete();
    tick();
    rst = 1'b0;
    check("rst_in_ready", PW'(obs_in_ready), PW'(1));

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step_offer(PW'(i), 1'b1, acc);
      check("stream_valid", PW'(obs_out_valid), PW'(1));
      check("stream_data", obs_out_data, PW'(i));
      check("stream_in_ready", PW'(obs_in_ready), PW'(1));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", PW'(obs_out_valid), '0);

    // Back-pressure then release.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      step_offer(lst[idx % 3], idx < 3, acc);
      if (acc) idx++;
    end
    check("bp_accepted", PW'(idx), sel ? PW'(2) : PW'(1));
    check("bp_in_ready", PW'(obs_in_ready), '0);
    check("bp_hold", obs_out_data, lst[0]);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("bp_no_gap", PW'(obs_out_valid), PW'(1));
      step_offer(lst[idx % 3], idx < 3, acc);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_in", PW'(idx), PW'(3));
    tick();
    check("bp_drained", PW'(obs_out_valid), '0);

    // Flush with held data.
    out_ready = 1'b0;
    step_offer(lst[0], 1'b1, acc);
    step_offer(lst[1], 1'b1, acc);
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_out_valid", PW'(obs_out_valid), '0);
    check("flush_out_data", obs_out_data, '0);
    check("flush_in_ready", PW'(obs_in_ready), PW'(1));
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("flush_no_ghost", PW'(obs_out_valid), '0);
    end

    // Flush with a concurrent input: it is dropped, the next one goes through.
    in_valid = 1'b1;
    in_data = lst[2];
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flin_dropped", PW'(obs_out_valid), '0);
    step_offer(lst[0], 1'b1, acc);
    check("flin_next_valid", PW'(obs_out_valid), PW'(1));
    check("flin_next_data", obs_out_data, lst[0]);
    in_valid = 1'b0;
    tick();

    // Stall counter, saturation (CNT_W=4 on the no-skid instance) and flush exclusion.
    do_reset();
    out_ready = 1'b0;
    step_offer(lst[1], 1'b1, acc);
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("cnt_20", PW'(obs_stall), sel ? PW'(20) : PW'(15));
    for (int k = 0; k < 5; k++) tick();
    check("cnt_25", PW'(obs_stall), sel ? PW'(25) : PW'(15));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("cnt_flush", PW'(obs_stall), sel ? PW'(25) : PW'(15));
    out_ready = 1'b1;
    tick();
    check("sb_drained", PW'(q.size()), '0);
  endtask

  initial begin
    sel = 1'b1;
    run_all();
    sel = 1'b0;
    run_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
